// File: rtl/pe_link_fifo.sv
// pe_link_fifo: show-ahead link buffer between a PE egress queue and the
// downstream cluster ingress, with stall counting and underflow tracking.
package pe_link_pkg;
  typedef logic [7:0] packet_t;
endpackage

module pe_link_fifo
  import pe_link_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int STALL_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       up_empty,
  input  packet_t                    up_rdata,
  output logic                       up_deq,
  input  logic                       dn_deq,
  output logic                       dn_empty,
  output packet_t                    dn_rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [STALL_W-1:0]         stall_cnt,
  output logic                       err_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  packet_t       mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          full;
  logic          push;
  logic          pop;

  // Flags come only from registered occupancy, so the
  // upstream pop never depends on the downstream pop.
  assign full     = (count == CW'(DEPTH));
  assign dn_empty = (count == '0);
  assign up_deq   = rst & ~up_empty & ~full;
  assign push     = up_deq;
  assign pop      = dn_deq & ~dn_empty;
  assign dn_rdata = dn_empty ? '0 : mem[rptr];

  // Storage write; contents survive reset, pointers do not.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= up_rdata;
  end

  // Pointer advance, wrapping naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
    end
  end

  // Occupancy; push is blocked when full and pop when empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Saturating count of cycles upstream had data but we were full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (~up_empty & full & ~&stall_cnt) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

  // Sticky record of a pop attempted on an empty buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_underflow <= 1'b0;
    end else if (dn_deq & dn_empty) begin
      err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pe_link_fifo.sv
// tb_pe_link_fifo: directed and random checks of pe_link_fifo
// against a queue-based reference model.
module tb_pe_link_fifo;
  import pe_link_pkg::*;

  localparam int DEPTH   = 4;
  localparam int STALL_W = 4;
  localparam int SMAX    = (1 << STALL_W) - 1;
  localparam int CW      = $clog2(DEPTH+1);

  logic               clk;
  logic               rst;
  logic               up_empty;
  packet_t            up_rdata;
  logic               up_deq;
  logic               dn_deq;
  logic               dn_empty;
  packet_t            dn_rdata;
  logic [CW-1:0]      count;
  logic [STALL_W-1:0] stall_cnt;
  logic               err_underflow;

  pe_link_fifo #(.DEPTH(DEPTH), .STALL_W(STALL_W)) dut (
    .clk(clk),
    .rst(rst),
    .up_empty(up_empty),
    .up_rdata(up_rdata),
    .up_deq(up_deq),
    .dn_deq(dn_deq),
    .dn_empty(dn_empty),
    .dn_rdata(dn_rdata),
    .count(count),
    .stall_cnt(stall_cnt),
    .err_underflow(err_underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  packet_t q[$];
  int      m_stall;
  bit      m_err;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    packet_t head;
    bit      exp_deq;
    head    = (q.size() > 0) ? q[0] : 8'h00;
    exp_deq = rst && !up_empty && (q.size() != DEPTH);
    chk("count", 32'(count), 32'(q.size()));
    chk("dn_empty", 32'(dn_empty), 32'(q.size() == 0));
    chk("dn_rdata", 32'(dn_rdata), 32'(head));
    chk("up_deq", 32'(up_deq), 32'(exp_deq));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    chk("err_underflow", 32'(err_underflow), 32'(m_err));
  endtask

  // Apply one cycle of inputs, check, then advance the model.
  task automatic step(input bit ue, input packet_t d, input bit dd);
    bit full;
    up_empty = ue;
    up_rdata = d;
    dn_deq   = dd;
    #1;
    check_all();
    full = (q.size() == DEPTH);
    if (!ue && full && m_stall < SMAX) m_stall++;
    if (dd) begin
      if (q.size() > 0) void'(q.pop_front());
      else m_err = 1'b1;
    end
    if (!ue && !full) q.push_back(d);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pulse reset in the low phase, away from any edge.
  task automatic pulse_reset();
    up_empty = 1'b0;
    dn_deq   = 1'b0;
    #2 rst = 1'b0;
    #1;
    q.delete();
    m_stall = 0;
    m_err   = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_dn_empty", 32'(dn_empty), 32'd1);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_up_deq", 32'(up_deq), 32'd0);
    chk("rst_dn_rdata", 32'(dn_rdata), 32'd0);
    chk("rst_err", 32'(err_underflow), 32'd0);
    up_empty = 1'b1;
    #1 rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst      = 1'b0;
    up_empty = 1'b0;
    up_rdata = '0;
    dn_deq   = 1'b0;
    m_stall  = 0;
    m_err    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_dn_empty", 32'(dn_empty), 32'd1);
    chk("reset_up_deq", 32'(up_deq), 32'd0);
    chk("reset_dn_rdata", 32'(dn_rdata), 32'd0);
    up_empty = 1'b1;
    rst = 1'b1;
    @(negedge clk);

    // single packet
    step(1'b0, 8'hA5, 1'b0);
    #1;
    chk("single_rdata", 32'(dn_rdata), 32'hA5);
    chk("single_count", 32'(count), 32'd1);
    step(1'b1, 8'h00, 1'b1);

    // underflow, sticky
    step(1'b1, 8'h00, 1'b1);
    #1;
    chk("uflow_flag", 32'(err_underflow), 32'd1);
    chk("uflow_rdata", 32'(dn_rdata), 32'd0);
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h00, 1'b0);

    // streaming 0..99 with continuous pop
    for (int i = 0; i < 100; i++) begin
      step(1'b0, packet_t'(i), 1'b1);
      chk("stream_le1", 32'(count <= 1), 32'd1);
    end
    chk("stream_stall", 32'(stall_cnt), 32'd0);
    step(1'b1, 8'h00, 1'b1);
    step(1'b1, 8'h00, 1'b1);

    // fill to full, then stall counting
    for (int i = 0; i < 8; i++) step(1'b0, packet_t'(8'h10 + i), 1'b0);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_stall", 32'(stall_cnt), 32'd4);

    // full plus one pop
    step(1'b0, 8'h77, 1'b1);
    chk("fpp_count", 32'(count), 32'd3);
    step(1'b0, 8'h78, 1'b0);
    chk("fpp_refill", 32'(count), 32'd4);

    // stall counter saturation
    for (int i = 0; i < 16; i++) step(1'b0, 8'h55, 1'b0);
    chk("stall_sat", 32'(stall_cnt), 32'(SMAX));

    // mid-operation reset from count=3, stall_cnt=7
    pulse_reset();
    for (int i = 0; i < 11; i++) step(1'b0, packet_t'(8'h30 + i), 1'b0);
    step(1'b1, 8'h00, 1'b1);
    chk("pre_rst_count", 32'(count), 32'd3);
    chk("pre_rst_stall", 32'(stall_cnt), 32'd7);
    pulse_reset();
    step(1'b0, 8'hC3, 1'b0);
    chk("post_rst_head", 32'(dn_rdata), 32'hC3);
    step(1'b0, 8'hC4, 1'b1);
    chk("post_rst_next", 32'(dn_rdata), 32'hC4);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit ue;
      bit dd;
      ue = ($urandom_range(0, 3) == 0);
      dd = ($urandom_range(0, 2) != 0);
      if (i >= 200 && i < 260) dd = ($urandom_range(0, 4) == 0);
      step(ue, packet_t'($urandom), dd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pe_link_fifo.md
PE_LINK_FIFO -- requirements
Module: pe_link_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, entries of buffering; legal values are powers of two >= 2.
REQ-002 SHALL have parameter STALL_W, default 16, width of the stall counter.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port up_empty  input  1  upstream egress queue has no packet.
REQ-007 SHALL have port up_rdata  input  packet_t  upstream head packet, valid when up_empty=0.
REQ-008 SHALL have port up_deq  output  1  pop upstream head this cycle.
REQ-009 SHALL have port dn_deq  input  1  downstream cluster ingress pops the head.
REQ-010 SHALL have port dn_empty  output  1  buffer holds no packet.
REQ-011 SHALL have port dn_rdata  output  packet_t  head packet (show-ahead).
REQ-012 SHALL have port count  output  $clog2(DEPTH+1)  current occupancy.
REQ-013 SHALL have port stall_cnt  output  STALL_W  cycles upstream was blocked by full.
REQ-014 SHALL have port err_underflow  output  1  sticky flag for a pop while empty.

Function
REQ-015 SHALL drive full = (count == DEPTH) and dn_empty = (count == 0), both from registered state only.
REQ-016 SHALL drive up_deq = rst & ~up_empty & ~full, with no combinational dependence on dn_deq.
REQ-017 SHALL write up_rdata into storage at wptr on each rising edge with up_deq=1, then advance wptr modulo DEPTH.
REQ-018 SHALL drive dn_rdata = storage[rptr] when dn_empty=0, and all-zero when dn_empty=1.
REQ-019 SHALL advance rptr modulo DEPTH on each edge with dn_deq=1 and dn_empty=0.
REQ-020 SHALL have a latency of one cycle: a packet popped upstream in cycle t appears on dn_rdata with dn_empty=0 in cycle t+1.
REQ-021 SHALL, on a simultaneous push and valid pop, leave count unchanged and move both pointers.
REQ-022 SHALL, when full and dn_deq=1, keep up_deq=0 that cycle; the slot is refilled in the next cycle.
REQ-023 SHALL sustain one packet per cycle in steady state when neither side stalls.
REQ-024 SHALL preserve packet order exactly (FIFO) and never drop or duplicate a packet.
REQ-025 SHALL, on dn_deq=1 while dn_empty=1, change no pointer or count and set err_underflow, which stays set until reset.
REQ-026 SHALL increment stall_cnt on each cycle with up_empty=0 and full=1, saturating at all-ones.
REQ-027 SHALL make count wrap-free: it is never above DEPTH and never below 0.

Reset
REQ-028 SHALL, while rst=0, asynchronously force wptr=0, rptr=0, count=0, stall_cnt=0 and err_underflow=0, giving dn_empty=1, dn_rdata=0 and up_deq=0.
REQ-029 SHALL discard all buffered packets when reset is asserted mid-operation; storage contents need not be cleared.
REQ-030 SHALL resume normal operation on the first rising edge after rst deasserts, with up_deq able to assert in that cycle.

Verification
REQ-031 SHALL pass single packet: rst released, push P=0xA5 once, dn_deq held 0 -> next cycle dn_empty=0, dn_rdata=0xA5, count=1.
REQ-032 SHALL pass fill to full: DEPTH=4, upstream always non-empty, dn_deq=0 -> up_deq high for 4 cycles then 0; count=4; stall_cnt increments by 1 per cycle thereafter.
REQ-033 SHALL pass streaming: upstream supplies 0,1,2,…,99 with dn_deq=1 continuously -> output is 0..99 in order, count never exceeds 1, stall_cnt=0.
REQ-034 SHALL pass full-plus-pop: count=4, dn_deq=1 for one cycle -> up_deq=0 that cycle, count=3, next cycle up_deq=1 and count returns to 4.
REQ-035 SHALL pass underflow: empty buffer, dn_deq=1 for one cycle -> count stays 0, dn_rdata=0, err_underflow=1 and stays 1 until reset.
REQ-036 SHALL pass mid-operation reset: count=3, stall_cnt=7, rst pulsed low between clock edges -> immediately count=0, dn_empty=1, stall_cnt=0, up_deq=0; after release, the first pushed packet is the first delivered.
